// File: rtl/hex_multi_display.sv
// Avalon-MM controlled multi-digit hex 7-segment driver with per-digit blank and blink.
// Optional leading-zero blanking is compiled in with the HEX_LZB_EN macro.
module hex_multi_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_W    = 24
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [1:0]              address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_BLANK  = 2'd1;
    localparam logic [1:0] ADDR_BLINK  = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;
    localparam logic [BLINK_W-1:0] CNT_ONE = 1;

    logic [DW-1:0]         data_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [NUM_DIGITS-1:0] blink_q;
    logic [BLINK_W-1:0]    period_q;
    logic [BLINK_W-1:0]    cnt_q;
    logic                  phase_q;
    logic [31:0]           rd_mux;
    logic [7*NUM_DIGITS-1:0] hex_d;
    logic                  digit_off;
    logic                  unused_wdata;

    // Upper writedata bits are don't-care for the narrower registers.
    assign unused_wdata = ^writedata;

`ifdef HEX_LZB_EN
    logic                  lzb_en_q;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  lz_seen;

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_blank = '0;
        lz_seen  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (data_q[4*i +: 4] != 4'h0) lz_seen = 1'b1;
            lz_blank[i] = lzb_en_q & ~lz_seen;
        end
    end
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // Bus: write takes effect on the edge it is sampled; read data appears one edge
    // after read=1 and then holds. No waitrequest, so every access completes at once.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_q   <= '0;
            blank_q  <= '0;
            blink_q  <= '0;
            period_q <= '0;
`ifdef HEX_LZB_EN
            lzb_en_q <= 1'b0;
`endif
        end else if (write) begin
            case (address)
                ADDR_DATA:  data_q <= writedata[DW-1:0];
                ADDR_BLANK: begin
                    blank_q <= writedata[NUM_DIGITS-1:0];
`ifdef HEX_LZB_EN
                    lzb_en_q <= writedata[31];
`endif
                end
                ADDR_BLINK:  blink_q  <= writedata[NUM_DIGITS-1:0];
                default:     period_q <= writedata[BLINK_W-1:0];
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:  rd_mux[DW-1:0] = data_q;
            ADDR_BLANK: begin
                rd_mux[NUM_DIGITS-1:0] = blank_q;
`ifdef HEX_LZB_EN
                rd_mux[31] = lzb_en_q;
`endif
            end
            ADDR_BLINK: rd_mux[NUM_DIGITS-1:0] = blink_q;
            default:    rd_mux[BLINK_W-1:0] = period_q;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) readdata <= '0;
        else if (read)      readdata <= rd_mux;
    end

    // A PERIOD write restarts the half-period so the new rate begins cleanly.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if ((write && address == ADDR_PERIOD) || period_q == '0) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q >= period_q - CNT_ONE) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        hex_d     = '1;
        digit_off = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_off = blank_q[i] | (blink_q[i] & phase_q);
`ifdef HEX_LZB_EN
            digit_off = digit_off | lz_blank[i];
`endif
            if (!digit_off) hex_d[7*i +: 7] = seg_decode(data_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) hex_out <= '1;
        else                hex_out <= hex_d;
    end

endmodule

// File: tb/tb_hex_multi_display.sv
// Bench for hex_multi_display: directed literal checks plus random bus traffic compared
// every cycle against a behavioural model of the display and register file.
module tb_hex_multi_display;

    localparam int N  = 6;
    localparam int BW = 24;
    localparam int HW = 7 * N;
    localparam logic [31:0] DMASK = 32'h00FF_FFFF;
    localparam logic [31:0] NMASK = 32'h0000_003F;
    localparam logic [31:0] PMASK = 32'h00FF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [HW-1:0] hex_out;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    hex_multi_display #(.NUM_DIGITS(N), .BLINK_W(BW)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .hex_out(hex_out)
    );

    // Lit segments of each hex glyph, by segment letter.
    string glyph_segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    logic [31:0]   m_data, m_blank, m_blink, m_period;
    logic          m_lzb;
    int            m_t;
    logic [HW-1:0] exp_hex;
    logic [31:0]   exp_rd;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] s;
        string g;
        s = 7'h7F;
        g = glyph_segs[v];
        for (int k = 0; k < g.len(); k++) begin
            int idx;
            idx = int'(g[k]) - 97;
            s[idx] = 1'b0;
        end
        return s;
    endfunction

    function automatic int m_phase();
        if (m_period == 32'd0) return 0;
        return (m_t / int'(m_period)) % 2;
    endfunction

    function automatic logic [HW-1:0] render();
        logic [HW-1:0] r;
        for (int i = 0; i < N; i++) begin
            logic off;
            logic [3:0] d;
            d   = m_data[4*i +: 4];
            off = m_blank[i] || (m_blink[i] && m_phase() == 1);
`ifdef HEX_LZB_EN
            if (m_lzb && i > 0 && (m_data >> (4*i)) == 32'd0) off = 1'b1;
`endif
            r[7*i +: 7] = off ? 7'h7F : glyph(int'(d));
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_data;
            2'd1:    return m_blank | {m_lzb, 31'd0};
            2'd2:    return m_blink;
            default: return m_period;
        endcase
    endfunction

    // Model: m_t counts edges since the last PERIOD write; phase is (m_t / PERIOD) mod 2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= 0; m_blank <= 0; m_blink <= 0; m_period <= 0; m_lzb <= 1'b0;
            m_t <= 0; exp_hex <= '1; exp_rd <= 0;
        end else begin
            exp_hex <= render();
            if (read) exp_rd <= m_read(address);
            m_t <= m_t + 1;
            if (write) begin
                case (address)
                    2'd0: m_data <= writedata & DMASK;
                    2'd1: begin
                        m_blank <= writedata & NMASK;
`ifdef HEX_LZB_EN
                        m_lzb <= writedata[31];
`endif
                    end
                    2'd2: m_blink <= writedata & NMASK;
                    default: begin
                        m_period <= writedata & PMASK;
                        m_t <= 0;
                    end
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_hex", 64'(hex_out), 64'(exp_hex));
            check("model_rd", 64'(readdata), 64'(exp_rd));
        end
    end

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic rw_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
    endtask

    localparam logic [HW-1:0] ALL_DARK  = '1;
    localparam logic [6:0]    G0 = 7'b1000000;
    localparam logic [6:0]    G2 = 7'b0100100;
    localparam logic [6:0]    G4 = 7'b0011001;
    localparam logic [6:0]    DK = 7'b1111111;
`ifdef HEX_LZB_EN
    localparam logic [31:0]   BLANK_RB  = 32'h8000_0000;
    localparam logic [HW-1:0] LZ42      = {DK, DK, DK, DK, G4, G2};
    localparam logic [HW-1:0] LZ00      = {DK, DK, DK, DK, DK, G0};
`else
    localparam logic [31:0]   BLANK_RB  = 32'h0000_0000;
    localparam logic [HW-1:0] LZ42      = {G0, G0, G0, G0, G4, G2};
    localparam logic [HW-1:0] LZ00      = {G0, G0, G0, G0, G0, G0};
`endif

    initial begin
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_hex", 64'(hex_out), 64'(ALL_DARK));
        check("reset_rd", 64'(readdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_zeros", 64'(hex_out), 64'({G0, G0, G0, G0, G0, G0}));

        write_reg(2'd0, 32'hFFAB_CDEF);
        @(negedge clk);
        check("data_abcdef", 64'(hex_out), 64'({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
        read_reg(2'd0);
        check("read_data", 64'(readdata), 64'h00AB_CDEF);
        read_reg(2'd3);
        check("read_period0", 64'(readdata), 64'd0);

        write_reg(2'd0, 32'h1);
        rw_reg(2'd0, 32'h2);
        check("rw_same_cycle_rd", 64'(readdata), 64'h1);
        @(negedge clk);
        check("rw_same_cycle_hex", 64'(hex_out), 64'({G0, G0, G0, G0, G0, G2}));

        write_reg(2'd2, 32'h1);
        write_reg(2'd3, 32'd4);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 2 || j == 6 || j == 10)
                check("blink_d0", 64'(hex_out[6:0]), 64'((j == 6) ? DK : G2));
        end
        write_reg(2'd3, 32'd0);
        @(negedge clk);
        check("blink_off_d0", 64'(hex_out[6:0]), 64'(G2));
        repeat (5) @(negedge clk);
        check("blink_off_steady", 64'(hex_out[6:0]), 64'(G2));

        write_reg(2'd3, 32'd1);
        write_reg(2'd1, 32'h3F);
        @(negedge clk);
        check("blank_all_a", 64'(hex_out), 64'(ALL_DARK));
        @(negedge clk);
        check("blank_all_b", 64'(hex_out), 64'(ALL_DARK));
        write_reg(2'd1, 32'h0);
        write_reg(2'd3, 32'd0);
        write_reg(2'd2, 32'h0);

        write_reg(2'd1, 32'h8000_0000);
        read_reg(2'd1);
        check("blank_bit31_rd", 64'(readdata), 64'(BLANK_RB));
        write_reg(2'd0, 32'h42);
        @(negedge clk);
        check("lzb_42", 64'(hex_out), 64'(LZ42));
        write_reg(2'd0, 32'h0);
        @(negedge clk);
        check("lzb_00", 64'(hex_out), 64'(LZ00));
        write_reg(2'd1, 32'h0);

        for (int it = 0; it < 3000; it++) begin
            int op;
            logic [1:0] a;
            logic [31:0] d;
            @(negedge clk);
            op = $urandom_range(0, 9);
            a  = 2'($urandom_range(0, 3));
            if (a == 2'd3)      d = $urandom_range(0, 6);
            else if (a == 2'd0) d = $urandom() >> $urandom_range(0, 31);
            else                d = $urandom();
            address   = a;
            writedata = d;
            write     = (op <= 3) || (op == 8);
            read      = (op >= 4 && op <= 6) || (op == 8);
            if (it == 1500) begin
                write = 1'b0; read = 1'b0;
                #3 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
